// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data bus access, load alignment, MEM/WB register
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int RF_AW    = 5,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic [RF_AW-1:0] ex_reg_regid,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_mem_funct3,
  input  logic [XLEN-1:0]  ex_store_data,
  output logic             mem_stall,
  output logic             dbus_req,
  output logic             dbus_write,
  output logic [XLEN-1:0]  dbus_addr,
  output logic [3:0]       dbus_byteen,
  output logic [XLEN-1:0]  dbus_wdata,
  input  logic             dbus_gnt,
  input  logic             dbus_rvalid,
  input  logic [XLEN-1:0]  dbus_rdata,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [RF_AW-1:0] wb_reg_regid,
  output logic [XLEN-1:0]  wb_reg_writedata,
  output logic             misaligned_exc,
  output logic             bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // Counter only needs to reach MAX_WAIT-1; MAX_WAIT=0 disables the timeout.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [1:0]       l_off;
  logic [2:0]       l_f3;
  logic [RF_AW-1:0] l_regid;
  logic             l_rw;

  logic             is_mem, misal, mem_go, busy, bus_done, timeout, finish;
  logic [3:0]       st_be;
  logic [XLEN-1:0]  st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_data;

  // Read and write together is illegal and never reaches the bus.
  assign is_mem   = ex_valid & (ex_mem_read ^ ex_mem_write);
  assign mem_go   = is_mem & ~misal;
  assign busy     = (state != IDLE);
  assign bus_done = ((state == REQ) & dbus_gnt & dbus_rvalid) | ((state == WAIT) & dbus_rvalid);
  assign timeout  = (MAX_WAIT > 0) && (wait_cnt == WAIT_LAST);
  assign finish   = busy & (bus_done | timeout);
  assign mem_stall = rst & (((state == IDLE) & mem_go) | (busy & ~finish));

  // Alignment check, byte enables and lane-replicated store data from the EX access size
  always_comb begin
    misal    = 1'b0;
    st_be    = 4'b1111;
    st_wdata = ex_store_data;
    case (ex_mem_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_alu_result[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        misal    = ex_alu_result[0];
        st_be    = 4'b0011 << {ex_alu_result[1], 1'b0};
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: misal = |ex_alu_result[1:0];
    endcase
  end

  // Select the addressed lane of the returned word and extend it to XLEN
  always_comb begin
    case (l_off)
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = l_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (l_f3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dbus_rdata;
    endcase
  end

  // Bus FSM plus MEM/WB register; bus fields are captured on REQ entry and held until done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      l_off            <= '0;
      l_f3             <= '0;
      l_regid          <= '0;
      l_rw             <= 1'b0;
      dbus_req         <= 1'b0;
      dbus_write       <= 1'b0;
      dbus_addr        <= '0;
      dbus_byteen      <= '0;
      dbus_wdata       <= '0;
      wb_valid         <= 1'b0;
      wb_reg_write     <= 1'b0;
      wb_reg_regid     <= '0;
      wb_reg_writedata <= '0;
      misaligned_exc   <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_go) begin
            state        <= REQ;
            wait_cnt     <= '0;
            dbus_req     <= 1'b1;
            dbus_write   <= ex_mem_write;
            dbus_addr    <= {ex_alu_result[XLEN-1:2], 2'b00};
            dbus_byteen  <= st_be;
            dbus_wdata   <= ex_mem_write ? st_wdata : '0;
            l_off        <= ex_alu_result[1:0];
            l_f3         <= ex_mem_funct3;
            l_regid      <= ex_reg_regid;
            l_rw         <= ex_reg_write & ex_mem_read;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end else begin
            wb_valid         <= ex_valid;
            wb_reg_write     <= ex_valid & ex_reg_write & ~(ex_mem_read | ex_mem_write);
            wb_reg_regid     <= ex_reg_regid;
            wb_reg_writedata <= ex_alu_result;
            misaligned_exc   <= is_mem & misal;
          end
        end
        REQ, WAIT: begin
          if (finish) begin
            state        <= IDLE;
            dbus_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_regid <= l_regid;
            if (bus_done) begin
              wb_reg_write     <= l_rw;
              wb_reg_writedata <= dbus_write ? '0 : ld_data;
            end else begin
              wb_reg_write     <= 1'b0;
              wb_reg_writedata <= '0;
              bus_err          <= 1'b1;
            end
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wait_cnt     <= wait_cnt + CW'(1);
            if ((state == REQ) && dbus_gnt) begin
              state    <= WAIT;
              dbus_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
